swacc_icm_lookup_arb: RTL
=========================

Name: swacc_icm_lookup_arb

Overview:
Round-robin arbiter that shares one ICM address-translation port (lookup request plus response) among the SWAccCMCtl context threads (QPC/CQC/EQC/MPT write paths).
- Allows one lookup outstanding at a time.
- Routes each response back to the thread that issued the lookup.
- Flags a sticky error when a response stalls.
- Sits between the thread bank and the ICM mapping table of the context cache.

Parameters:
N_REQ, 4, number of requesting threads (2..8)
IDX_W, 24, lookup index width
ICM_W, 64, ICM space address width (ICM_SPACE_ADDR_WIDTH)
PHY_W, 64, physical address width (PHY_SPACE_ADDR_WIDTH)
TIMEOUT, 1024, cycles allowed in RSP before err_timeout sets (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-thread lookup valid
req_head  in  N_REQ*IDX_W  per-thread index; slice i = [i*IDX_W +: IDX_W]
req_ready  out  N_REQ  per-thread lookup accept
rsp_valid  out  N_REQ  per-thread response valid
rsp_icm_addr  out  ICM_W  response ICM address, broadcast to all threads
rsp_phy_addr  out  PHY_W  response physical address, broadcast to all threads
rsp_ready  in  N_REQ  per-thread response accept
dn_lookup_valid  out  1  downstream lookup valid
dn_lookup_head  out  IDX_W  downstream index
dn_lookup_ready  in  1  downstream accept
dn_rsp_valid  in  1  downstream response valid
dn_rsp_icm_addr  in  ICM_W  downstream ICM address
dn_rsp_phy_addr  in  PHY_W  downstream physical address
dn_rsp_ready  out  1  downstream response accept
err_timeout  out  1  sticky: a response exceeded TIMEOUT cycles
grant_cnt  out  16  completed lookups, wraps at 0xFFFF

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE.
  - gnt (one-hot) 0, head_q 0.
  - last_ptr N_REQ-1, so thread 0 wins first.
  - Timer 0, err_timeout 0, grant_cnt 0.
  - All outputs 0.
- State machine IDLE -> REQ -> RSP -> IDLE:
  - IDLE: if any req_valid, select the first set bit searching from last_ptr+1 modulo N_REQ. Latch gnt and head_q = that thread's req_head. Go to REQ. If none are valid, stay in IDLE.
  - REQ: dn_lookup_valid=1 and dn_lookup_head=head_q. req_ready[g] = dn_lookup_ready; all other req_ready bits are 0. On the dn_lookup handshake go to RSP.
  - RSP:
    - Steering: rsp_valid[g] = dn_rsp_valid and dn_rsp_ready = rsp_ready[g]. Other rsp_valid bits are 0.
    - Address outputs: rsp_icm_addr and rsp_phy_addr pass the downstream values combinationally.
    - On the response handshake: last_ptr <= g, grant_cnt += 1, gnt <= 0, go to IDLE.
- Latency:
  - First cycle of requester valid to dn_lookup_valid: 1 cycle.
  - Responses pass through combinationally.
  - One IDLE bubble between transactions, so at most one lookup per 3 cycles.
- Head and valid rules:
  - head_q is captured only in IDLE; later changes to req_head are ignored.
  - Requesters hold valid until ready, as the threads do in ADDR_REQ.
- Fairness: a requester that drops valid before its grant is simply skipped. With all threads requesting continuously, grants follow 0,1,2,3,0...
- Simultaneous events: new req_valid bits seen in REQ or RSP are arbitrated only at the next IDLE.
- Timeout:
  - The timer clears on entering RSP and increments each RSP cycle without a handshake.
  - When timer == TIMEOUT-1, err_timeout sets. It clears only on reset.
  - Setting the flag does not abort the transaction; the block keeps waiting.
- Reset mid-transaction: everything returns to reset values immediately. Any in-flight downstream response is dropped, and it is the system's responsibility to reset the downstream block too.
- dn_rsp_ready is 0 outside RSP. A dn_rsp_valid that arrives outside RSP is held off, not consumed.

Decomposition:
- Shared package: IDX_W/ICM_W/PHY_W defaults taken from the ICM width macros (ICM_SPACE_ADDR_WIDTH, PHY_SPACE_ADDR_WIDTH, log2b of ICM_ENTRY_NUM), plus state encodings IDLE=2'd0, REQ=2'd1, RSP=2'd2.
- One sub-module, rr_pick: combinational function of (valid vector, last_ptr) returning one-hot grant and its index, reusable for the cache-set arbiter.
- FSM, latches, timer and counters stay in the top module.

Test Plan:
- Single request: req_valid=4'b0100, head 0x123, dn_lookup_ready=1.
  - dn_lookup_valid rises 1 cycle later with head 0x123.
  - req_ready[2] pulses.
  - A response with icm 0xA000, phy 0xB000 gives rsp_valid[2]=1 with those addresses, and grant_cnt becomes 1.
- All four threads request continuously with a 1-cycle response: grant order 0,1,2,3,0, and each lookup occupies 3 cycles.
- Backpressure:
  - dn_lookup_ready held low 5 cycles: req_ready stays 0 and head is stable.
  - rsp_ready[g] low 3 cycles while dn_rsp_valid=1: dn_rsp_ready=0 and state stays RSP.
- TIMEOUT=8 with no dn_rsp_valid: err_timeout=1 on the 8th RSP cycle. A later response still completes, and the flag stays set.
- rst_n asserted in RSP: all outputs 0 asynchronously. After release, thread 0 wins first when req_valid=4'b1111.
- Thread 1 drops valid while thread 0 is in RSP, with threads 2 and 3 valid: next grant goes to 2.

Source files
------------

// File: rtl/swacc_icm_lookup_arb_pkg.sv
// Shared types and width defaults for the ICM lookup arbiter and its helpers.
// Widths follow the context-cache ICM macros unless the integrator overrides them.
`ifndef ICM_SPACE_ADDR_WIDTH
`define ICM_SPACE_ADDR_WIDTH 64
`endif
`ifndef PHY_SPACE_ADDR_WIDTH
`define PHY_SPACE_ADDR_WIDTH 64
`endif
`ifndef ICM_ENTRY_NUM
`define ICM_ENTRY_NUM (1 << 24)
`endif

package swacc_icm_lookup_arb_pkg;

    localparam int ICM_W_DEF = `ICM_SPACE_ADDR_WIDTH;
    localparam int PHY_W_DEF = `PHY_SPACE_ADDR_WIDTH;
    localparam int IDX_W_DEF = $clog2(`ICM_ENTRY_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Slot reached by stepping 'off' positions past 'last' in a ring of n (off <= n).
    function automatic int rr_slot(input int last, input int off, input int n);
        int s;
        s = last + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/swacc_icm_lookup_arb_if.sv
// Thread-side and downstream-side handshake bundle of the ICM lookup arbiter.
// slave = the arbiter's view; master = thread bank plus ICM table (or a testbench).
interface swacc_icm_lookup_arb_if
    import swacc_icm_lookup_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = IDX_W_DEF,
    parameter int ICM_W = ICM_W_DEF,
    parameter int PHY_W = PHY_W_DEF
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*IDX_W-1:0] req_head;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [ICM_W-1:0]       rsp_icm_addr;
    logic [PHY_W-1:0]       rsp_phy_addr;
    logic [N_REQ-1:0]       rsp_ready;
    logic                   dn_lookup_valid;
    logic [IDX_W-1:0]       dn_lookup_head;
    logic                   dn_lookup_ready;
    logic                   dn_rsp_valid;
    logic [ICM_W-1:0]       dn_rsp_icm_addr;
    logic [PHY_W-1:0]       dn_rsp_phy_addr;
    logic                   dn_rsp_ready;

    modport slave (
        input  req_valid, req_head, rsp_ready,
        input  dn_lookup_ready, dn_rsp_valid, dn_rsp_icm_addr, dn_rsp_phy_addr,
        output req_ready, rsp_valid, rsp_icm_addr, rsp_phy_addr,
        output dn_lookup_valid, dn_lookup_head, dn_rsp_ready
    );

    modport master (
        output req_valid, req_head, rsp_ready,
        output dn_lookup_ready, dn_rsp_valid, dn_rsp_icm_addr, dn_rsp_phy_addr,
        input  req_ready, rsp_valid, rsp_icm_addr, rsp_phy_addr,
        input  dn_lookup_valid, dn_lookup_head, dn_rsp_ready
    );
endinterface

// File: rtl/swacc_icm_lookup_arb_rr_pick.sv
// Combinational round-robin pick: first valid bit after last_ptr, wrapping at N_REQ.
// Returns the winner one-hot and as an index; gnt is all-zero when nothing is valid.
module swacc_icm_lookup_arb_rr_pick
    import swacc_icm_lookup_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    last_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx
);
    logic found;

    always_comb begin
        // NOTE: every output gets a default before the search so no path infers a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && valid[i] && (i == rr_slot(int'(last_ptr), off, N_REQ))) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = PW'(i);
                end
            end
        end
    end
endmodule

// File: rtl/swacc_icm_lookup_arb.sv
// Round-robin sharing of the single ICM translation port among context threads.
// One lookup in flight; the response is steered back to the granted thread.
module swacc_icm_lookup_arb
    import swacc_icm_lookup_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int ICM_W   = ICM_W_DEF,
    parameter int PHY_W   = PHY_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    swacc_icm_lookup_arb_if.slave bus,
    output logic                err_timeout,
    output logic [15:0]         grant_cnt
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    state_t           state;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] pick_gnt;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    last_ptr;
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] pick_head;
    logic [TW-1:0]    timer;
    logic             in_req;
    logic             in_rsp;
    logic             rsp_hs;

    swacc_icm_lookup_arb_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .valid    (bus.req_valid),
        .last_ptr (last_ptr),
        .gnt      (pick_gnt),
        .idx      (pick_idx)
    );

    always_comb begin
        pick_head = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) pick_head = bus.req_head[i*IDX_W +: IDX_W];
        end
    end

    assign in_req = (state == REQ);
    assign in_rsp = (state == RSP);
    assign rsp_hs = bus.dn_rsp_valid && bus.dn_rsp_ready;

    assign bus.dn_lookup_valid = in_req;
    assign bus.dn_lookup_head  = in_req ? head_q : '0;
    assign bus.req_ready       = in_req ? (gnt & {N_REQ{bus.dn_lookup_ready}}) : '0;
    // Response side is a pure pass-through, gated so everything idles at 0 outside RSP.
    assign bus.rsp_valid       = in_rsp ? (gnt & {N_REQ{bus.dn_rsp_valid}}) : '0;
    assign bus.dn_rsp_ready    = in_rsp && |(gnt & bus.rsp_ready);
    assign bus.rsp_icm_addr    = in_rsp ? bus.dn_rsp_icm_addr : '0;
    assign bus.rsp_phy_addr    = in_rsp ? bus.dn_rsp_phy_addr : '0;

    // NOTE: non-blocking assignments so every flop here samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            head_q      <= '0;
            last_ptr    <= PW'(N_REQ - 1);
            timer       <= '0;
            err_timeout <= 1'b0;
            grant_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        gnt     <= pick_gnt;
                        gnt_idx <= pick_idx;
                        head_q  <= pick_head;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.dn_lookup_ready) begin
                        timer <= '0;
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_hs) begin
                        last_ptr  <= gnt_idx;
                        grant_cnt <= grant_cnt + 16'd1;
                        gnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        // Flag rises together with the timer reaching TIMEOUT-1; timer saturates.
                        if (timer != TW'(TIMEOUT - 1)) timer <= timer + 1'b1;
                        if (timer == TW'(TIMEOUT - 2)) err_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
